// File: rtl/fetch_unit.sv
// Instruction fetch unit.
// Issues single-outstanding reads to instruction memory, buffers the returned
// words with their addresses in a small prefetch queue, and presents one
// registered instruction per cycle to decode.
//
// Memory handshake:
//   imem_req is the request valid and imem_addr is its payload. Once imem_req
//   rises, both hold steady until the cycle in which imem_ack=1. imem_ack is the
//   ready/complete strobe. The transfer happens in any cycle where
//   imem_req && imem_ack, and imem_rdata is valid in that same cycle.
//   The ack can come in the first request cycle. Only one request is ever
//   outstanding.
//
// On a redirect (is_branch_taken) the queue is flushed and fetch restarts at
// branch_target. A request that is already in flight cannot be withdrawn. It is
// finished in the DROP state and its data is thrown away.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        is_branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] pc_out,
    output logic        instr_valid,
    output logic [1:0]  dbg_state
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   fpc, fpc_nxt;
    logic [15:0]   drop_addr, drop_addr_nxt;

    logic [15:0]   q_pc   [QDEPTH];
    logic [15:0]   q_data [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_push;

    logic          push;
    logic          pop;
    logic          q_empty;

    assign q_empty   = (count == '0);
    assign dbg_state = state;

    // Pop happens whenever decode can take a word and no redirect overrides it.
    assign pop = !is_branch_taken && !stall && !q_empty;

    // Occupancy after this cycle's push and pop. It decides whether another request may follow.
    assign count_after_push = count + CW'(1) - (pop ? CW'(1) : CW'(0));

    // Memory FSM next-state, fetch PC update and request outputs.
    always_comb begin
        state_nxt     = state;
        fpc_nxt       = fpc;
        drop_addr_nxt = drop_addr;
        push          = 1'b0;
        imem_req      = 1'b0;
        imem_addr     = fpc;
        case (state)
            ST_IDLE: begin
                if (is_branch_taken) begin
                    fpc_nxt   = branch_target;
                    state_nxt = ST_REQ;
                end else if (count < QDEPTH_C) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (is_branch_taken) begin
                    fpc_nxt = branch_target;
                    if (imem_ack) begin
                        state_nxt = ST_REQ;
                    end else begin
                        // Keep presenting the old address until memory finishes it.
                        drop_addr_nxt = fpc;
                        state_nxt     = ST_DROP;
                    end
                end else if (imem_ack) begin
                    push    = 1'b1;
                    fpc_nxt = fpc + 16'd1;
                    if (count_after_push < QDEPTH_C) begin
                        state_nxt = ST_REQ;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr;
                if (is_branch_taken) begin
                    // Last redirect wins. An ack in the same cycle still ends the old request.
                    fpc_nxt = branch_target;
                end
                if (imem_ack) begin
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, fetch PC and held drop address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            fpc       <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state     <= state_nxt;
            fpc       <= fpc_nxt;
            drop_addr <= drop_addr_nxt;
        end
    end

    // Queue pointers and occupancy. A redirect empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (is_branch_taken) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage. Entries are only read when the count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= fpc;
            q_data[wr_ptr] <= imem_rdata;
        end
    end

    // Registered decode-side outputs. Redirect clears them, stall holds them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr       <= 16'h0000;
            pc_out      <= 16'h0000;
            instr_valid <= 1'b0;
        end else if (is_branch_taken) begin
            instr       <= 16'h0000;
            pc_out      <= 16'h0000;
            instr_valid <= 1'b0;
        end else if (!stall) begin
            if (!q_empty) begin
                instr       <= q_data[rd_ptr];
                pc_out      <= q_pc[rd_ptr];
                instr_valid <= 1'b1;
            end else begin
                instr       <= 16'h0000;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
// The memory model returns word[a] = a + 16'h1000. A second instance starts at
// 16'hFFFE and streams continuously so that PC wraparound can be observed.
module tb_fetch_unit;

    localparam logic [15:0] S_IDLE = 16'd0;
    localparam logic [15:0] S_REQ  = 16'd1;
    localparam logic [15:0] S_DROP = 16'd2;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br;
    logic [15:0] target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [15:0] pc_out;
    logic        instr_valid;
    logic [1:0]  dbg_state;

    logic        reset_w;
    logic        stall_w;
    logic        br_w;
    logic [15:0] target_w;
    logic        imem_req_w;
    logic [15:0] imem_addr_w;
    logic        imem_ack_w;
    logic [15:0] imem_rdata_w;
    logic [15:0] instr_w;
    logic [15:0] pc_out_w;
    logic        instr_valid_w;
    logic [1:0]  dbg_state_w;

    int total = 0;
    int bad   = 0;

    assign imem_rdata   = imem_addr + 16'h1000;
    assign imem_rdata_w = imem_addr_w + 16'h1000;

    fetch_unit #(.RESET_PC(16'h0000), .QDEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .stall(stall),
        .is_branch_taken(br), .branch_target(target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid),
        .dbg_state(dbg_state)
    );

    fetch_unit #(.RESET_PC(16'hFFFE), .QDEPTH(4)) u_wrap (
        .clk(clk), .reset(reset_w), .stall(stall_w),
        .is_branch_taken(br_w), .branch_target(target_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
        .instr(instr_w), .pc_out(pc_out_w), .instr_valid(instr_valid_w),
        .dbg_state(dbg_state_w)
    );

    // Clock and reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset   = 1'b1;
        reset_w = 1'b1;
    end

    // One cycle: pass the active edge, then return to the falling edge for checks and drives.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        stall      = 1'b0;
        br         = 1'b0;
        target     = 16'h0000;
        imem_ack   = 1'b0;
        stall_w    = 1'b0;
        br_w       = 1'b0;
        target_w   = 16'h0000;
        imem_ack_w = 1'b1;

        // Reset values, including acks arriving while reset is held.
        repeat (2) tick();
        check1 ("rst_req",    imem_req, 1'b0);
        check16("rst_addr",   imem_addr, 16'h0000);
        check16("rst_instr",  instr, 16'h0000);
        check16("rst_pc",     pc_out, 16'h0000);
        check1 ("rst_valid",  instr_valid, 1'b0);
        check16("rst_state",  16'(dbg_state), S_IDLE);
        check16("rst_addr_w", imem_addr_w, 16'hFFFE);
        imem_ack = 1'b1;
        tick();
        check1 ("rst_ack_req",   imem_req, 1'b0);
        check1 ("rst_ack_valid", instr_valid, 1'b0);

        // Streaming with a constant ack.
        reset   = 1'b0;
        reset_w = 1'b0;
        tick();
        check1 ("first_req",   imem_req, 1'b1);
        check16("first_addr",  imem_addr, 16'h0000);
        check1 ("first_valid", instr_valid, 1'b0);
        check16("first_state", 16'(dbg_state), S_REQ);
        check16("first_addr_w", imem_addr_w, 16'hFFFE);
        tick();
        check16("second_addr",  imem_addr, 16'h0001);
        check1 ("second_valid", instr_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check16("stream_instr", instr, 16'h1000 + 16'(k));
            check16("stream_pc",    pc_out, 16'(k));
            check1 ("stream_valid", instr_valid, 1'b1);
            check16("wrap_pc",      pc_out_w, 16'hFFFE + 16'(k));
            check16("wrap_instr",   instr_w, 16'h0FFE + 16'(k));
            check1 ("wrap_valid",   instr_valid_w, 1'b1);
        end

        // Backpressure: outputs hold while the queue fills and the requests stop.
        stall = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            check16("stall_instr", instr, 16'h1003);
            check16("stall_pc",    pc_out, 16'h0003);
            check1 ("stall_valid", instr_valid, 1'b1);
        end
        check1 ("stall_req",   imem_req, 1'b0);
        check16("stall_state", 16'(dbg_state), S_IDLE);
        stall = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            check16("drain_instr", instr, 16'h1004 + 16'(j));
            check16("drain_pc",    pc_out, 16'h0004 + 16'(j));
            check1 ("drain_valid", instr_valid, 1'b1);
        end

        // Asynchronous reset in the middle of a request.
        reset = 1'b1;
        #1;
        check1 ("arst_req",   imem_req, 1'b0);
        check1 ("arst_valid", instr_valid, 1'b0);
        check16("arst_instr", instr, 16'h0000);
        check16("arst_pc",    pc_out, 16'h0000);
        check16("arst_addr",  imem_addr, 16'h0000);
        tick();
        reset = 1'b0;

        // Redirect while a request to 0x0005 is outstanding, with the ack arriving late.
        repeat (6) tick();
        check16("pre_instr", instr, 16'h1003);
        check16("pre_addr",  imem_addr, 16'h0005);
        imem_ack = 1'b0;
        tick();
        check16("wait_instr", instr, 16'h1004);
        check16("wait_pc",    pc_out, 16'h0004);
        check16("wait_addr",  imem_addr, 16'h0005);
        tick();
        check1 ("empty_valid", instr_valid, 1'b0);
        check16("empty_instr", instr, 16'h0000);
        check16("empty_pc",    pc_out, 16'h0004);
        br     = 1'b1;
        target = 16'h0040;
        tick();
        check16("drop_state", 16'(dbg_state), S_DROP);
        check1 ("drop_req",   imem_req, 1'b1);
        check16("drop_addr",  imem_addr, 16'h0005);
        check1 ("drop_valid", instr_valid, 1'b0);
        check16("drop_pc",    pc_out, 16'h0000);
        br = 1'b0;
        tick();
        check16("drop_hold_addr", imem_addr, 16'h0005);
        check16("drop_hold_state", 16'(dbg_state), S_DROP);
        imem_ack = 1'b1;
        tick();
        check16("redir_state", 16'(dbg_state), S_REQ);
        check16("redir_addr",  imem_addr, 16'h0040);
        check1 ("redir_valid", instr_valid, 1'b0);
        tick();
        check1 ("redir_valid2", instr_valid, 1'b0);
        check16("redir_addr2",  imem_addr, 16'h0041);
        tick();
        check16("redir_instr", instr, 16'h1040);
        check16("redir_pc",    pc_out, 16'h0040);
        check1 ("redir_valid3", instr_valid, 1'b1);

        // Redirect, ack and stall all high in the same cycle.
        stall  = 1'b1;
        br     = 1'b1;
        target = 16'h0080;
        tick();
        check16("sim_instr", instr, 16'h0000);
        check1 ("sim_valid", instr_valid, 1'b0);
        check16("sim_pc",    pc_out, 16'h0000);
        check16("sim_addr",  imem_addr, 16'h0080);
        check1 ("sim_req",   imem_req, 1'b1);
        br       = 1'b0;
        imem_ack = 1'b0;
        tick();
        check1 ("sim_hold_valid", instr_valid, 1'b0);
        stall = 1'b0;
        tick();
        check1 ("sim_flushed_valid", instr_valid, 1'b0);
        check16("sim_flushed_addr",  imem_addr, 16'h0080);
        imem_ack = 1'b1;
        repeat (2) tick();
        check16("sim_instr2", instr, 16'h1080);
        check16("sim_pc2",    pc_out, 16'h0080);

        // Two redirects back to back: the second target wins once the dropped request finishes.
        imem_ack = 1'b0;
        br       = 1'b1;
        target   = 16'h0100;
        tick();
        check16("dd_state1", 16'(dbg_state), S_DROP);
        check16("dd_addr1",  imem_addr, 16'h0082);
        target = 16'h0200;
        tick();
        check16("dd_state2", 16'(dbg_state), S_DROP);
        check16("dd_addr2",  imem_addr, 16'h0082);
        check1 ("dd_valid",  instr_valid, 1'b0);
        br       = 1'b0;
        imem_ack = 1'b1;
        tick();
        check16("dd_state3", 16'(dbg_state), S_REQ);
        check16("dd_addr3",  imem_addr, 16'h0200);
        repeat (2) tick();
        check16("dd_instr", instr, 16'h1200);
        check16("dd_pc",    pc_out, 16'h0200);
        check1 ("dd_valid2", instr_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, address of the first instruction fetched after reset.
REQ-002 Parameter QDEPTH, default 4, prefetch queue depth in entries; SHALL be a power of 2, 2..16.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-006 is_branch_taken  input  1  redirect request from execute.
REQ-007 branch_target  input  16  redirect word address; sampled when is_branch_taken=1.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  16  word address of the current request.
REQ-010 imem_ack  input  1  read complete; imem_rdata valid in the same cycle.
REQ-011 imem_rdata  input  16  fetched instruction word.
REQ-012 instr  output  16  instruction to decode; 16'h0000 (NOP) when no valid instruction.
REQ-013 pc_out  output  16  address of instr.
REQ-014 instr_valid  output  1  instr/pc_out hold a real fetched instruction.

Function
REQ-015 Internal fetch PC (fpc, 16 bit) is word-addressed and increments by 1 on every accepted ack; it wraps from 16'hFFFF to 16'h0000.
REQ-016 Memory FSM states:
- IDLE: imem_req=0.
- REQ: imem_req=1, imem_addr=fpc.
- DROP: imem_req=1, imem_addr held at the pre-redirect address.
REQ-017 Memory handshake rules:
- At most one outstanding request.
- imem_req and imem_addr stay constant from assertion until the cycle imem_ack=1.
- An ack can arrive in the first request cycle or later.
REQ-018 IDLE->REQ when (queue count + outstanding) < QDEPTH. REQ->REQ on ack if there is still space after the push; otherwise REQ->IDLE on ack.
REQ-019 In REQ, an ack with no redirect pushes {fpc, imem_rdata} into the queue and advances fpc.
REQ-020 Redirect (is_branch_taken=1) has priority over stall and ack. In the same cycle it SHALL:
- flush the queue to empty;
- set fpc to branch_target;
- load the output register with instr=16'h0000, instr_valid=0, pc_out=0.
REQ-021 Redirect while in REQ with no ack that cycle: go to DROP. The later ack is discarded (no push, fpc unchanged). DROP->REQ on that ack.
REQ-022 Redirect in the same cycle as an ack: imem_rdata is discarded. Next state is REQ at branch_target.
REQ-023 Redirect while in DROP: stay in DROP and take the new branch_target (last redirect wins).
REQ-024 Output register update, when there is no redirect:
- stall=0 and queue non-empty: pop the head into instr/pc_out and set instr_valid=1.
- stall=0 and queue empty: instr=16'h0000, instr_valid=0, pc_out unchanged.
- stall=1: instr, pc_out and instr_valid hold their values.
REQ-025 A push and a pop in the same cycle leave the queue count unchanged. The queue SHALL never overflow; pop on empty is a no-op.
REQ-026 Minimum latency: data acked at edge N is in the queue after N and appears on instr after edge N+1.
REQ-027 With imem_ack tied to 1 and stall=0, throughput SHALL be one instruction per cycle after the initial fill.
REQ-028 instr and pc_out SHALL be registered outputs, with no combinational path from memory inputs.

Reset
REQ-029 While reset=1, asynchronously:
- fpc=RESET_PC, queue empty, FSM=IDLE;
- imem_req=0, imem_addr=RESET_PC;
- instr=16'h0000, pc_out=16'h0000, instr_valid=0.
REQ-030 Reset asserted mid-request abandons the request. Any ack received while reset=1 is ignored.
REQ-031 First request SHALL be issued in the first cycle after reset deasserts.

Verification
REQ-032 Streaming: reset release, imem_ack=1 constant, memory word[a]=a+16'h1000, stall=0 -> instr sequence 1000,1001,1002... with pc_out 0,1,2..., valid every cycle from the 3rd cycle onward.
REQ-033 Stall/backpressure: stream, then stall=1 for 6 cycles -> instr and pc_out hold; queue fills to 4, imem_req drops to 0. On release, 4 queued instructions emerge in order with no gap or duplicate.
REQ-034 Redirect with late ack: request to 0x0005 outstanding, is_branch_taken=1 with branch_target=0x0040, ack 2 cycles later -> that ack is dropped; the next imem_addr is 0x0040; the first valid pc_out after the redirect is 0x0040, with instr_valid=0 in between.
REQ-035 Simultaneous redirect, ack and stall: all three high in the same cycle -> imem_rdata discarded, queue emptied, instr=0 with instr_valid=0, next imem_addr=branch_target.
REQ-036 Wrap and reset: RESET_PC=16'hFFFE, streaming -> pc_out FFFE, FFFF, 0000. Asserting reset asynchronously mid-request -> imem_req=0 and instr_valid=0 before the next clock edge.
